stream_mux_rr: RTL and testbench

Parametrised N-input stream multiplexer with valid/ready handshakes, round-robin arbitration and a registered output. It generalises the team's combinational 2:1/4:1 selectors. Width and channel count are parameters, and the select comes from either a fair arbiter or a forced channel index. It sits between several producer streams and one consumer and merges them without loss under backpressure.

---
 rtl/stream_mux_rr.sv | 112 +++++++++++
 tb/tb_stream_mux_rr.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-input valid/ready stream merger with round-robin or forced
// channel selection feeding a single registered output slot.
module stream_mux_rr #(
   parameter int WIDTH = 4,
   parameter int N     = 4,
   parameter int SEL_W = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         in_valid,
   input  logic [N*WIDTH-1:0]   in_data,
   output logic [N-1:0]         in_ready,
   input  logic                 force_en,
   input  logic [SEL_W-1:0]     force_sel,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_W-1:0]     out_sel,
   input  logic                 out_ready
);

   // Channel that won the most recent transfer; the search starts just after it.
   logic [SEL_W-1:0] last_grant;

   // Combinational grant result for the current cycle.
   logic             gnt_vld;
   logic [SEL_W-1:0] gnt_idx;
   logic [WIDTH-1:0] gnt_data;

   // Output slot is free or being emptied this cycle.
   logic             load;
   logic             xfer;

   // Distance bookkeeping for the rotating priority search.
   int               rr_dist;
   int               rr_best;

   assign load = !out_valid || out_ready;
   assign xfer = gnt_vld && load;

   // Pick the granted channel: forced index, or nearest valid channel after last_grant.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      rr_dist = 0;
      rr_best = N;
      if (force_en) begin
         // Out-of-range indices match no channel, so they never grant.
         for (int i = 0; i < N; i++) begin
            if (force_sel == SEL_W'(i) && in_valid[i]) begin
               gnt_vld = 1'b1;
               gnt_idx = SEL_W'(i);
            end
         end
      end else begin
         // Distance 0 is last_grant+1, distance N-1 is last_grant itself.
         for (int i = 0; i < N; i++) begin
            rr_dist = i - int'(last_grant) - 1;
            if (rr_dist < 0) begin
               rr_dist = rr_dist + N;
            end
            if (in_valid[i] && rr_dist < rr_best) begin
               rr_best = rr_dist;
               gnt_vld = 1'b1;
               gnt_idx = SEL_W'(i);
            end
         end
      end
   end

   // Route the granted channel's word toward the output register.
   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_idx == SEL_W'(i)) begin
            gnt_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Ready goes only to the granted channel, and only when the slot can take a word.
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         in_ready[i] = gnt_vld && (gnt_idx == SEL_W'(i)) && load;
      end
   end

   // Output register and pointer: refill on transfer, empty on drain, hold on stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_sel    <= '0;
         last_grant <= SEL_W'(N - 1);
      end else if (load) begin
         out_valid <= xfer;
         if (xfer) begin
            out_data   <= gnt_data;
            out_sel    <= gnt_idx;
            last_grant <= gnt_idx;
         end
      end
   end

   // At most one producer is ever offered ready.
   a_ready_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));

   // A stalled word must stay put until the consumer takes it.
   a_stall_stable : assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_sel) && out_valid));

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance for rotation, stall and
// forced-mode scenarios, and a 3-channel instance for wrap and mid-stream reset.
module tb_stream_mux_rr;

   localparam int W  = 4;
   localparam int N4 = 4;
   localparam int N3 = 3;
   localparam int S4 = $clog2(N4);
   localparam int S3 = $clog2(N3);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 4-channel instance signals
   logic             rst;
   logic [N4-1:0]    in_valid;
   logic [N4*W-1:0]  in_data;
   logic [N4-1:0]    in_ready;
   logic             force_en;
   logic [S4-1:0]    force_sel;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic [S4-1:0]    out_sel;
   logic             out_ready;

   // 3-channel instance signals
   logic             rst3;
   logic [N3-1:0]    in_valid3;
   logic [N3*W-1:0]  in_data3;
   logic [N3-1:0]    in_ready3;
   logic             force_en3;
   logic [S3-1:0]    force_sel3;
   logic             out_valid3;
   logic [W-1:0]     out_data3;
   logic [S3-1:0]    out_sel3;
   logic             out_ready3;

   int n_checks = 0;
   int n_fail   = 0;

   stream_mux_rr #(.WIDTH(W), .N(N4)) u4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .force_en(force_en), .force_sel(force_sel), .out_valid(out_valid),
      .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
   );

   stream_mux_rr #(.WIDTH(W), .N(N3)) u3 (
      .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
      .force_en(force_en3), .force_sel(force_sel3), .out_valid(out_valid3),
      .out_data(out_data3), .out_sel(out_sel3), .out_ready(out_ready3)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset4();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      in_valid  = 4'hF;
      in_data   = 16'h4321;
      out_ready = 1'b1;
      force_en  = 1'b0;
      force_sel = '0;
      rst       = 1'b1;
      for (int c = 0; c < 2; c++) begin
         step();
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid[%0d]: got %b expected 0", c, out_valid);
         end
         n_checks++;
         if (out_data !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_data[%0d]: got %0d expected 0", c, out_data);
         end
         n_checks++;
         if (out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_sel[%0d]: got %0d expected 0", c, out_sel);
         end
      end
      n_checks++;
      if (in_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL reset_ready: got %b expected 0001", in_ready);
      end
      rst = 1'b0;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 4'd1 || out_sel !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_first_word: got v=%b d=%0d s=%0d expected v=1 d=1 s=0",
                  out_valid, out_data, out_sel);
      end
   endtask

   task automatic test_rotation();
      logic [3:0] exp_rdy;
      logic [3:0] exp_d;
      logic [1:0] exp_s;
      in_valid  = 4'hF;
      in_data   = 16'h4321;
      out_ready = 1'b1;
      force_en  = 1'b0;
      reset4();
      for (int k = 0; k < 8; k++) begin
         step();
         exp_d   = 4'((k % 4) + 1);
         exp_s   = 2'(k % 4);
         exp_rdy = 4'(1 << ((k + 1) % 4));
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== exp_d || out_sel !== exp_s) begin
            n_fail++;
            $display("FAIL rot_word[%0d]: got v=%b d=%0d s=%0d expected v=1 d=%0d s=%0d",
                     k, out_valid, out_data, out_sel, exp_d, exp_s);
         end
         n_checks++;
         if (in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL rot_ready[%0d]: got %b expected %b", k, in_ready, exp_rdy);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] exp_d;
      logic [1:0] exp_s;
      in_valid  = 4'hF;
      in_data   = 16'h4321;
      out_ready = 1'b1;
      force_en  = 1'b0;
      reset4();
      step();
      step();
      n_checks++;
      if (out_data !== 4'd2 || out_sel !== 2'd1) begin
         n_fail++;
         $display("FAIL bp_pre: got d=%0d s=%0d expected d=2 s=1", out_data, out_sel);
      end
      out_ready = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL bp_ready_now: got %b expected 0000", in_ready);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 4'd2 || out_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got v=%b d=%0d s=%0d expected v=1 d=2 s=1",
                     c, out_valid, out_data, out_sel);
         end
         n_checks++;
         if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_ready[%0d]: got %b expected 0000", c, in_ready);
         end
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         exp_s = 2'((k + 2) % 4);
         exp_d = 4'(((k + 2) % 4) + 1);
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== exp_d || out_sel !== exp_s) begin
            n_fail++;
            $display("FAIL bp_resume[%0d]: got v=%b d=%0d s=%0d expected v=1 d=%0d s=%0d",
                     k, out_valid, out_data, out_sel, exp_d, exp_s);
         end
      end
   endtask

   task automatic test_forced();
      in_valid  = 4'hF;
      in_data   = 16'h4321;
      out_ready = 1'b1;
      force_en  = 1'b1;
      force_sel = 2'd2;
      reset4();
      for (int k = 0; k < 4; k++) begin
         step();
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 4'd3 || out_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL force_word[%0d]: got v=%b d=%0d s=%0d expected v=1 d=3 s=2",
                     k, out_valid, out_data, out_sel);
         end
         n_checks++;
         if (in_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL force_ready[%0d]: got %b expected 0100", k, in_ready);
         end
      end
      force_sel = 2'd3;
      in_valid  = 4'b0111;
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL force_idle_ready: got %b expected 0000", in_ready);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 4'd3 || out_sel !== 2'd2) begin
         n_fail++;
         $display("FAIL force_drop: got v=%b d=%0d s=%0d expected v=0 d=3 s=2",
                  out_valid, out_data, out_sel);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL force_stay_empty: got %b expected 0", out_valid);
      end
      force_en = 1'b0;
      in_valid = 4'hF;
   endtask

   task automatic test_sparse();
      logic [1:0] exp_s;
      logic [3:0] exp_d;
      in_valid  = 4'b1010;
      in_data   = 16'h4321;
      out_ready = 1'b1;
      force_en  = 1'b0;
      reset4();
      for (int k = 0; k < 4; k++) begin
         step();
         exp_s = (k % 2 == 0) ? 2'd1 : 2'd3;
         exp_d = (k % 2 == 0) ? 4'd2 : 4'd4;
         n_checks++;
         if (out_valid !== 1'b1 || out_sel !== exp_s || out_data !== exp_d) begin
            n_fail++;
            $display("FAIL sparse[%0d]: got v=%b d=%0d s=%0d expected v=1 d=%0d s=%0d",
                     k, out_valid, out_data, out_sel, exp_d, exp_s);
         end
      end
   endtask

   task automatic test_mid_reset_n3();
      logic [1:0] exp_s;
      logic [3:0] exp_d;
      in_valid3  = 3'b111;
      in_data3   = 12'h321;
      out_ready3 = 1'b1;
      force_en3  = 1'b0;
      force_sel3 = '0;
      rst3       = 1'b1;
      step();
      step();
      rst3 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
      end
      n_checks++;
      if (out_valid3 !== 1'b1 || out_sel3 !== 2'd2 || out_data3 !== 4'd3) begin
         n_fail++;
         $display("FAIL n3_pre: got v=%b d=%0d s=%0d expected v=1 d=3 s=2",
                  out_valid3, out_data3, out_sel3);
      end
      rst3 = 1'b1;
      step();
      n_checks++;
      if (out_valid3 !== 1'b0 || out_data3 !== 4'd0 || out_sel3 !== 2'd0) begin
         n_fail++;
         $display("FAIL n3_reset: got v=%b d=%0d s=%0d expected v=0 d=0 s=0",
                  out_valid3, out_data3, out_sel3);
      end
      rst3 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         exp_s = 2'(k % 3);
         exp_d = 4'((k % 3) + 1);
         n_checks++;
         if (out_valid3 !== 1'b1 || out_sel3 !== exp_s || out_data3 !== exp_d) begin
            n_fail++;
            $display("FAIL n3_wrap[%0d]: got v=%b d=%0d s=%0d expected v=1 d=%0d s=%0d",
                     k, out_valid3, out_data3, out_sel3, exp_d, exp_s);
         end
      end
   endtask

   task automatic test_force_range_n3();
      force_en3  = 1'b1;
      force_sel3 = 2'd3;
      #1;
      n_checks++;
      if (in_ready3 !== 3'b000) begin
         n_fail++;
         $display("FAIL n3_oor_ready: got %b expected 000", in_ready3);
      end
      step();
      n_checks++;
      if (out_valid3 !== 1'b0) begin
         n_fail++;
         $display("FAIL n3_oor_valid: got %b expected 0", out_valid3);
      end
      force_sel3 = 2'd1;
      #1;
      n_checks++;
      if (in_ready3 !== 3'b010) begin
         n_fail++;
         $display("FAIL n3_force_ready: got %b expected 010", in_ready3);
      end
      step();
      n_checks++;
      if (out_valid3 !== 1'b1 || out_data3 !== 4'd2 || out_sel3 !== 2'd1) begin
         n_fail++;
         $display("FAIL n3_force_word: got v=%b d=%0d s=%0d expected v=1 d=2 s=1",
                  out_valid3, out_data3, out_sel3);
      end
   endtask

   initial begin
      rst        = 1'b1;
      in_valid   = '0;
      in_data    = '0;
      force_en   = 1'b0;
      force_sel  = '0;
      out_ready  = 1'b1;
      rst3       = 1'b1;
      in_valid3  = '0;
      in_data3   = '0;
      force_en3  = 1'b0;
      force_sel3 = '0;
      out_ready3 = 1'b1;
      test_reset();
      test_rotation();
      test_backpressure();
      test_forced();
      test_sparse();
      test_mid_reset_n3();
      test_force_range_n3();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
